rx_frame_assembler: RTL and testbench
=====================================

# rx_frame_assembler

Collects the byte stream delivered by the UART receiver (RxData/RxDone) into one framed, checksum-verified M-bit operand word for the FSM/SR_receive/AND_com datapath. It sits directly downstream of UART_top's receive side and upstream of the operand register. It hunts for a header byte, gathers the payload bytes LSB-first, checks an XOR checksum, and presents the word with a valid/ack handshake. It also reports malformed, stalled or overrun traffic.

## Interface

- M, 8: payload width in bits (1..64); NB = ceil(M/8) payload bytes per frame.
- HDR, 8'hA5: frame header byte value.
- TIMEOUT, 40000: maximum idle cycles between bytes inside a frame (10 ms at 4 MHz); must be ≥2.

- Clk  input  1  system clock (4 MHz domain).
- Rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- RxData  input  8  received byte; valid only in a cycle where RxDone=1.
- RxDone  input  1  one-cycle pulse per received byte.
- FrameAck  input  1  consumer has taken FrameData; sampled only while FrameValid=1.
- FrameData  output  M  assembled payload; byte k occupies bits [8k+7:8k], truncated to M.
- FrameValid  output  1  FrameData holds a verified frame awaiting FrameAck.
- FrameErr  output  1  one-cycle pulse: checksum mismatch or inter-byte timeout.
- Overrun  output  1  one-cycle pulse: byte received while FrameValid=1 (byte discarded).
- Busy  output  1  high in PAYLOAD or CHECK.

## Operation

- States: IDLE, PAYLOAD, CHECK, HOLD. Reset → IDLE.
- IDLE: on RxDone with RxData==HDR → PAYLOAD, clear byte index, checksum accumulator and timer. Any other byte is ignored silently.
- PAYLOAD: each RxDone writes RxData into shadow byte [index] and XORs it into the accumulator. The transition to CHECK is taken on the NB-th byte.
- CHECK: on RxDone, if RxData == accumulator → copy the shadow register to FrameData, go to HOLD. Otherwise pulse FrameErr and go to IDLE; FrameData is unchanged.
- A header-valued byte inside PAYLOAD/CHECK is treated as data, not a resync.
- HOLD: FrameValid=1 and FrameData is stable. FrameAck → IDLE. RxDone in HOLD pulses Overrun and drops the byte, including in the same cycle as FrameAck.
- Timeout: the timer counts cycles in PAYLOAD/CHECK and resets on every RxDone. When it reaches TIMEOUT-1 without RxDone, the block pulses FrameErr and goes to IDLE. If RxDone and expiry fall in the same cycle, RxDone wins: the byte is accepted and the timer is reset.
- When M is not a multiple of 8, the upper bits of the last byte enter the checksum but are not stored in FrameData.
- Checksum = XOR of all NB payload bytes; the header byte is excluded.

## Timing

- Reset values: FrameData=0, FrameValid=0, FrameErr=0, Overrun=0, Busy=0; timer, index and accumulator are 0.
- All outputs are registered.
- FrameValid rises the cycle after the checksum-byte RxDone. It falls the cycle after FrameAck.
- FrameErr and Overrun are high for exactly one cycle, the cycle after the causing event.
- Busy rises the cycle after the header RxDone. It falls the cycle after the checksum byte or the timeout.
- A header byte can be accepted in the first IDLE cycle after HOLD or after an error, with no dead cycles.
- Asserting Rst_n low mid-frame or in HOLD immediately forces reset values; the partial frame is lost.
- Back-to-back RxDone on consecutive cycles is legal and is handled at full rate.

## Test plan

- M=16: bytes A5,34,12,26 → FrameValid=1 with FrameData=16'h1234 one cycle after the 26 byte; FrameAck → FrameValid=0 next cycle.
- M=16: bytes A5,34,12,27 → one-cycle FrameErr, FrameValid stays 0, FrameData keeps its old value, Busy=0.
- Garbage 00,FF,5A before A5,01,00,01 → garbage ignored, FrameData=16'h0001.
- TIMEOUT=10: send A5,34 then wait 10 cycles → FrameErr pulse at expiry, IDLE. Repeat with RxDone exactly on the expiry cycle → byte accepted, no error.
- In HOLD, send byte 55 in the same cycle as FrameAck → Overrun pulse, byte dropped, state IDLE. A following A5 frame completes normally.
- M=12: bytes A5,CD,FB,36 → FrameData=12'hBCD. Assert Rst_n low after A5,CD → all outputs return to 0; a subsequent full frame is assembled correctly.

Source files
------------

// File: rtl/rx_frame_assembler_if.sv
// Receive-side byte stream in, framed operand word out.
// The M parameter must match the M of the rx_frame_assembler that uses this interface.
interface rx_frame_assembler_if #(parameter int M = 8);
  logic [7:0]   RxData;
  logic         RxDone;
  logic         FrameAck;
  logic [M-1:0] FrameData;
  logic         FrameValid;
  logic         FrameErr;
  logic         Overrun;
  logic         Busy;

  modport master (output RxData, RxDone, FrameAck,
                  input  FrameData, FrameValid, FrameErr, Overrun, Busy);
  modport slave  (input  RxData, RxDone, FrameAck,
                  output FrameData, FrameValid, FrameErr, Overrun, Busy);
endinterface

// File: rtl/rx_frame_assembler.sv
// Hunts for a header byte, gathers NB payload bytes LSB-first, verifies an XOR
// checksum byte and holds the resulting M-bit word until it is acknowledged.
module rx_frame_assembler #(
  parameter int          M       = 8,
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int          TIMEOUT = 40000
) (
  input logic              Clk,
  input logic              Rst_n,
  rx_frame_assembler_if.slave rx
);
  localparam int NB = (M + 7) / 8;
  localparam int SW = NB * 8;
  localparam int IW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]    state, stateNxt;
  logic [IW-1:0] idx;
  logic [7:0]    acc;
  logic [TW-1:0] timer;
  logic [SW-1:0] shadow;
  logic          inFrame, expire, sumOk, errNxt;

  assign inFrame = (state == PAYLOAD) || (state == CHECK);
  assign expire  = (timer == TW'(TIMEOUT - 1));
  assign sumOk   = (rx.RxData == acc);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign errNxt  = (state == CHECK && rx.RxDone && !sumOk) ||
                   (inFrame && !rx.RxDone && expire);

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (rx.RxDone && rx.RxData == HDR) stateNxt = PAYLOAD;
      PAYLOAD: begin
        if (rx.RxDone) begin
          if (idx == IW'(NB - 1)) stateNxt = CHECK;
        end else if (expire) begin
          stateNxt = IDLE;
        end
      end
      CHECK: begin
        if (rx.RxDone)   stateNxt = sumOk ? HOLD : IDLE;
        else if (expire) stateNxt = IDLE;
      end
      default: if (rx.FrameAck) stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      acc           <= '0;
      timer         <= '0;
      shadow        <= '0;
      rx.FrameData  <= '0;
      rx.FrameValid <= 1'b0;
      rx.FrameErr   <= 1'b0;
      rx.Overrun    <= 1'b0;
      rx.Busy       <= 1'b0;
    end else begin
      state         <= stateNxt;
      rx.FrameValid <= (stateNxt == HOLD);
      rx.Busy       <= (stateNxt == PAYLOAD) || (stateNxt == CHECK);
      rx.FrameErr   <= errNxt;
      rx.Overrun    <= (state == HOLD) && rx.RxDone;

      if (state == IDLE && rx.RxDone && rx.RxData == HDR) begin
        idx   <= '0;
        acc   <= '0;
        timer <= '0;
      end else if (inFrame) begin
        if (rx.RxDone) timer <= '0;
        else if (!expire) timer <= timer + TW'(1);
      end

      if (state == PAYLOAD && rx.RxDone) begin
        // Upper bits of a partial last byte still feed the checksum.
        acc <= acc ^ rx.RxData;
        idx <= idx + IW'(1);
        for (int k = 0; k < NB; k++)
          if (idx == IW'(k)) shadow[8*k +: 8] <= rx.RxData;
      end

      if (state == CHECK && rx.RxDone && sumOk) rx.FrameData <= shadow[M-1:0];
    end
  end
endmodule

// File: tb/tb_rx_frame_assembler.sv
// Two assemblers (M=16 and M=12, TIMEOUT=10) checked every cycle against a
// byte-list reference model, plus table vectors and hand-written corner cases.
module tb_rx_frame_assembler;
  localparam int         TO  = 10;
  localparam logic [7:0] HDR = 8'hA5;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  rx_frame_assembler_if #(.M(16)) if0 ();
  rx_frame_assembler_if #(.M(12)) if1 ();

  rx_frame_assembler #(.M(16), .HDR(HDR), .TIMEOUT(TO)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .rx(if0));
  rx_frame_assembler #(.M(12), .HDR(HDR), .TIMEOUT(TO)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .rx(if1));

  logic [7:0] dData [2];
  logic       dDone [2];
  logic       dAck  [2];
  assign if0.RxData = dData[0];  assign if0.RxDone = dDone[0];  assign if0.FrameAck = dAck[0];
  assign if1.RxData = dData[1];  assign if1.RxDone = dDone[1];  assign if1.FrameAck = dAck[1];

  logic [15:0] oData [2];
  logic oValid [2], oErr [2], oOvr [2], oBusy [2];
  assign oData[0] = if0.FrameData;          assign oData[1] = {4'h0, if1.FrameData};
  assign oValid[0] = if0.FrameValid;        assign oValid[1] = if1.FrameValid;
  assign oErr[0] = if0.FrameErr;            assign oErr[1] = if1.FrameErr;
  assign oOvr[0] = if0.Overrun;             assign oOvr[1] = if1.Overrun;
  assign oBusy[0] = if0.Busy;               assign oBusy[1] = if1.Busy;

  int checks = 0;
  int errors = 0;

  // Reference model: a list of collected bytes and an idle-cycle count.
  int          mw [2] = '{16, 12};
  bit          mBusy [2], mHold [2];
  int          mIdle [2], mN [2];
  logic [7:0]  mB [2][8];
  logic [15:0] eData [2];
  bit          eErr [2], eOvr [2];

  function automatic int nbOf(int d);
    return (mw[d] + 7) / 8;
  endfunction

  task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mBusy[d] = 0; mHold[d] = 0; mIdle[d] = 0; mN[d] = 0;
      eData[d] = '0; eErr[d] = 0; eOvr[d] = 0;
    end
  endtask

  task automatic modelStep(int d);
    logic [7:0]  x;
    logic [63:0] w;
    x = '0; w = '0;
    eErr[d] = 0; eOvr[d] = 0;
    if (mHold[d]) begin
      if (dDone[d]) eOvr[d] = 1;
      if (dAck[d])  mHold[d] = 0;
    end else if (!mBusy[d]) begin
      if (dDone[d] && dData[d] == HDR) begin
        mBusy[d] = 1; mN[d] = 0; mIdle[d] = 0;
      end
    end else if (dDone[d]) begin
      mIdle[d] = 0;
      if (mN[d] < nbOf(d)) begin
        mB[d][mN[d]] = dData[d];
        mN[d]++;
      end else begin
        for (int k = 0; k < nbOf(d); k++) begin
          x = x ^ mB[d][k];
          w = w | (64'(mB[d][k]) << (8 * k));
        end
        mBusy[d] = 0;
        if (x == dData[d]) begin
          mHold[d] = 1;
          eData[d] = 16'(w & ((64'd1 << mw[d]) - 64'd1));
        end else begin
          eErr[d] = 1;
        end
      end
    end else begin
      mIdle[d]++;
      if (mIdle[d] == TO) begin
        eErr[d] = 1; mBusy[d] = 0;
      end
    end
  endtask

  task automatic cycle();
    for (int d = 0; d < 2; d++) modelStep(d);
    @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, 16'(oValid[d]), 16'(mHold[d]));
      chk("busy",  d, 16'(oBusy[d]),  16'(mBusy[d]));
      chk("err",   d, 16'(oErr[d]),   16'(eErr[d]));
      chk("ovr",   d, 16'(oOvr[d]),   16'(eOvr[d]));
      chk("data",  d, oData[d],       eData[d]);
      dDone[d] = 0; dAck[d] = 0;
    end
  endtask

  task automatic sendBytes(int d, logic [63:0] bs, int n);
    for (int i = 0; i < n; i++) begin
      dDone[d] = 1;
      dData[d] = bs[8*i +: 8];
      cycle();
    end
  endtask

  task automatic ackFrame(int d);
    dAck[d] = 1;
    cycle();
    chk("ack_valid", d, 16'(oValid[d]), 16'h0);
  endtask

  task automatic doReset();
    Rst_n = 1'b0;
    modelReset();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, 16'(oValid[d]), 16'h0);
      chk("rst_busy",  d, 16'(oBusy[d]),  16'h0);
      chk("rst_err",   d, 16'(oErr[d]),   16'h0);
      chk("rst_ovr",   d, 16'(oOvr[d]),   16'h0);
      chk("rst_data",  d, oData[d],       16'h0);
    end
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  typedef struct {
    int          d;
    int          n;
    logic [63:0] bs;
    logic        expValid;
    logic        expErr;
    logic [15:0] expData;
  } vec_t;

  vec_t tbl [4];

  // Random traffic generator state
  logic [7:0] gB [2][16];
  int gLen [2], gPos [2], gGap [2];

  task automatic refill(int d);
    logic [7:0] b, x;
    gPos[d] = 0;
    if ($urandom % 4 == 0) begin
      b = 8'($urandom);
      gB[d][0] = (b == HDR) ? 8'h00 : b;
      gLen[d] = 1;
    end else begin
      x = '0;
      gB[d][0] = HDR;
      for (int k = 0; k < nbOf(d); k++) begin
        b = 8'($urandom);
        gB[d][1 + k] = b;
        x = x ^ b;
      end
      if ($urandom % 5 == 0) x = ~x;
      gB[d][1 + nbOf(d)] = x;
      gLen[d] = nbOf(d) + 2;
    end
  endtask

  initial begin
    int r;
    for (int d = 0; d < 2; d++) begin
      dData[d] = '0; dDone[d] = 0; dAck[d] = 0;
      gLen[d] = 0; gPos[d] = 0; gGap[d] = 0;
    end
    tbl[0] = '{0, 4, 64'h26_12_34_A5, 1'b1, 1'b0, 16'h1234};
    tbl[1] = '{0, 4, 64'h27_12_34_A5, 1'b0, 1'b1, 16'h1234};
    tbl[2] = '{0, 7, 64'h01_00_01_A5_5A_FF_00, 1'b1, 1'b0, 16'h0001};
    tbl[3] = '{1, 4, 64'h36_FB_CD_A5, 1'b1, 1'b0, 16'h0BCD};

    doReset();

    foreach (tbl[i]) begin
      sendBytes(tbl[i].d, tbl[i].bs, tbl[i].n);
      chk("tbl_valid", tbl[i].d, 16'(oValid[tbl[i].d]), 16'(tbl[i].expValid));
      chk("tbl_err",   tbl[i].d, 16'(oErr[tbl[i].d]),   16'(tbl[i].expErr));
      chk("tbl_busy",  tbl[i].d, 16'(oBusy[tbl[i].d]),  16'h0);
      chk("tbl_data",  tbl[i].d, oData[tbl[i].d],       tbl[i].expData);
      if (tbl[i].expValid) ackFrame(tbl[i].d);
      else begin
        cycle();
        chk("tbl_errpulse", tbl[i].d, 16'(oErr[tbl[i].d]), 16'h0);
      end
    end

    // Inter-byte timeout expires on the 10th silent cycle
    sendBytes(0, 64'h34_A5, 2);
    repeat (TO - 1) cycle();
    chk("to_busy_before", 0, 16'(oBusy[0]), 16'h1);
    chk("to_err_before",  0, 16'(oErr[0]),  16'h0);
    cycle();
    chk("to_err",  0, 16'(oErr[0]),  16'h1);
    chk("to_busy", 0, 16'(oBusy[0]), 16'h0);

    // Byte landing exactly on the expiry cycle is accepted
    sendBytes(0, 64'h34_A5, 2);
    repeat (TO - 1) cycle();
    sendBytes(0, 64'h12, 1);
    chk("edge_err",  0, 16'(oErr[0]),  16'h0);
    chk("edge_busy", 0, 16'(oBusy[0]), 16'h1);
    sendBytes(0, 64'h26, 1);
    chk("edge_valid", 0, 16'(oValid[0]), 16'h1);
    chk("edge_data",  0, oData[0],       16'h1234);

    // Overrun coinciding with FrameAck, then an immediate new frame
    dDone[0] = 1; dData[0] = 8'h55; dAck[0] = 1;
    cycle();
    chk("ovr_pulse", 0, 16'(oOvr[0]),   16'h1);
    chk("ovr_valid", 0, 16'(oValid[0]), 16'h0);
    sendBytes(0, 64'h01_00_01_A5, 4);
    chk("post_ovr_valid", 0, 16'(oValid[0]), 16'h1);
    chk("post_ovr_data",  0, oData[0],       16'h0001);
    ackFrame(0);

    // Reset mid-frame on the M=12 unit
    sendBytes(1, 64'hCD_A5, 2);
    chk("m12_busy", 1, 16'(oBusy[1]), 16'h1);
    doReset();
    sendBytes(1, 64'h36_FB_CD_A5, 4);
    chk("m12_valid", 1, 16'(oValid[1]), 16'h1);
    chk("m12_data",  1, oData[1],       16'h0BCD);
    ackFrame(1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (gPos[d] >= gLen[d]) refill(d);
        if (gGap[d] > 0) begin
          gGap[d]--;
          dDone[d] = 0;
        end else begin
          dDone[d] = 1;
          dData[d] = gB[d][gPos[d]];
          gPos[d]++;
          r = int'($urandom % 20);
          gGap[d] = (r < 12) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : (r == 18) ? TO - 1 : TO;
        end
        dAck[d] = ($urandom % 3 == 0);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
